bb_queue_ctrl: RTL and testbench
================================

// Module: bb_queue_ctrl
// PURPOSE
//  Allocation/retire/flush controller for the 64-slot circular basic-block queue.
//  Owns the write side: produces the in_ptr (newest slot) and out_ptr (oldest slot)
//  that downstream flush-range and first-one logic consume.
//  Enqueues at tail, retires at head, rolls tail back on branch flush.
//  Publishes the per-slot valid vector and the vector of slots killed by each flush.
// PARAMETERS
//  DEPTH  64  queue slots; power of two
//  PTR_W  6   log2(DEPTH)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  enq_vld    in   1      producer offers a new basic block
//  enq_rdy    out  1      slot available: ~full & ~flush_vld
//  enq_ptr    out  PTR_W  slot taken by this cycle's enqueue (tail_ptr+1)
//  deq_vld    out  1      head slot holds a valid entry (~empty)
//  deq_rdy    in   1      consumer retires the head this cycle
//  deq_ptr    out  PTR_W  head (oldest) slot
//  in_ptr     out  PTR_W  tail (newest allocated) slot
//  flush_vld  in   1      branch flush request
//  flush_ptr  in   PTR_W  cur_ptr: this slot is kept; all younger slots are flushed
//  flush_vec  out  DEPTH  combinational; slots killed this cycle
//  flush_err  out  1      registered one-cycle pulse; flush_ptr was not a valid slot
//  valid_vec  out  DEPTH  registered; 1 = slot allocated
//  count      out  PTR_W+1 occupied slots, 0..DEPTH
//  full       out  1      count==DEPTH
//  empty      out  1      count==0
// BEHAVIOUR
//  Reset (async, rst_n=0): head=0, tail=DEPTH-1, count=0, valid_vec=0, flush_err=0.
//    Outputs: empty=1, full=0, enq_ptr=0, deq_vld=0.
//  enq_fire = enq_vld & enq_rdy.
//    Next cycle: tail=enq_ptr, valid_vec[enq_ptr]=1, count+1.
//  deq_fire = deq_vld & deq_rdy.
//    Next cycle: valid_vec[head]=0, head=head+1, count-1.
//  Pointer arithmetic is modulo DEPTH; wrap from 63 to 0 is silent.
//  Enqueue and dequeue in the same cycle: count is unchanged, both pointers advance.
//  flush_ok = flush_vld & valid_vec[flush_ptr].
//    flush_vec = circular range (flush_ptr, tail]:
//      - non-wrapped: slots greater than flush_ptr AND less than or equal to tail;
//      - wrapped: slots greater than flush_ptr OR less than or equal to tail.
//    flush_vec = 0 when flush_ptr==tail or when flush_ok=0.
//    Next cycle: tail=flush_ptr, valid_vec &= ~flush_vec, count=((flush_ptr-head) mod DEPTH)+1.
//  flush_vld blocks enqueue: enq_rdy=0, so the enqueue is not accepted.
//  Flush and dequeue in the same cycle:
//    - the dequeue is still honoured;
//    - count = ((flush_ptr-head) mod DEPTH)+1-deq_fire;
//    - flush_ptr==head with deq_fire gives empty next cycle (tail=head_old, head=head_old+1).
//  flush_vld with an invalid flush_ptr: no state change; flush_err=1 on the next cycle.
//  Full: enq_rdy=0. Empty: deq_vld=0, and deq_rdy is ignored.
//  Invariant: valid_vec equals the circular range [head, tail] when count>0, and 0 when count==0.
//  Latency: all registered outputs update 1 cycle after the fire; flush_vec has 0-cycle latency.
// STRUCTURE
//  bbq_pkg:
//    - constants BBQ_DEPTH=64 and BBQ_PTR_W=6;
//    - typedef bbq_ptr_t = logic [5:0];
//    - typedef bbq_vec_t = logic [63:0].
//  Sub-module ptr_range_mask(lo_ptr, hi_ptr, mask):
//    - circular (lo, hi] mask; mask=0 when lo==hi;
//    - instanced once for flush_vec.
//  Registers: head, tail, count, valid_vec, flush_err. enq_ptr/deq_ptr/full/empty are decoded from them.
// TESTING
//  T1 reset -> empty=1, count=0, enq_ptr=0, deq_vld=0, valid_vec=0, flush_err=0.
//  T2 64 back-to-back enqueues:
//     -> full=1, enq_rdy=0, count=64, valid_vec=all ones, in_ptr=63.
//     65th enq_vld is dropped; no state change.
//  T3 wrap: 64 enq, 10 deq, 5 enq with head full stall honoured:
//     -> head=10, in_ptr=4, count=59, valid_vec[9:5]=0, all other bits 1.
//  T4 head=0, tail=20, flush_ptr=12:
//     -> flush_vec bits 13..20 only; next cycle tail=12, count=13, enq_ptr=13.
//  T5 wrapped, head=60, tail=5, flush_ptr=62:
//     -> flush_vec bits 63 and 0..5; next cycle count=3, valid_vec bits 60..62 set.
//  T6 head=tail=7, count=1, enq_vld+deq_rdy+flush_vld with flush_ptr=7
//     -> enq dropped, flush_vec=0, next cycle empty=1, head=8.
//     Then flush_ptr=30 while empty -> flush_err=1 for one cycle, state unchanged.

Source files
------------

// File: rtl/bbq_pkg.sv
// Shared constants and types for the 64-slot basic-block queue controller.
package bbq_pkg;

  localparam int BBQ_DEPTH = 64;
  localparam int BBQ_PTR_W = 6;

  typedef logic [BBQ_PTR_W-1:0] bbq_ptr_t;
  typedef logic [BBQ_DEPTH-1:0] bbq_vec_t;
  typedef logic [BBQ_PTR_W:0]   bbq_cnt_t;

endpackage

// File: rtl/ptr_range_mask.sv
// Circular half-open range mask: bit i set when slot i lies in (lo_ptr, hi_ptr].
// An empty range (lo_ptr == hi_ptr) yields an all-zero mask.
module ptr_range_mask
  import bbq_pkg::*;
(
  input  bbq_ptr_t lo_ptr,
  input  bbq_ptr_t hi_ptr,
  output bbq_vec_t mask
);

  bbq_ptr_t idx;

  // Per-slot membership test; the wrapped case uses OR because the range crosses slot 0.
  always_comb begin
    mask = '0;
    idx  = '0;
    for (int i = 0; i < BBQ_DEPTH; i++) begin
      idx = i[BBQ_PTR_W-1:0];
      if (lo_ptr < hi_ptr)
        mask[i] = (idx > lo_ptr) && (idx <= hi_ptr);
      else if (lo_ptr > hi_ptr)
        mask[i] = (idx > lo_ptr) || (idx <= hi_ptr);
    end
  end

endmodule

// File: rtl/bb_queue_ctrl.sv
// Allocation / retire / flush controller for the circular basic-block queue.
// Tail holds the newest allocated slot, head the oldest; a flush rolls the
// tail back to the kept slot and kills everything younger.
module bb_queue_ctrl
  import bbq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_vld,
  output logic                 enq_rdy,
  output logic [BBQ_PTR_W-1:0] enq_ptr,
  output logic                 deq_vld,
  input  logic                 deq_rdy,
  output logic [BBQ_PTR_W-1:0] deq_ptr,
  output logic [BBQ_PTR_W-1:0] in_ptr,
  input  logic                 flush_vld,
  input  logic [BBQ_PTR_W-1:0] flush_ptr,
  output logic [BBQ_DEPTH-1:0] flush_vec,
  output logic                 flush_err,
  output logic [BBQ_DEPTH-1:0] valid_vec,
  output logic [BBQ_PTR_W:0]   count,
  output logic                 full,
  output logic                 empty
);

  bbq_ptr_t head, tail;
  bbq_cnt_t cnt;
  bbq_vec_t vld;
  bbq_vec_t range_mask;
  bbq_vec_t vld_next;
  bbq_cnt_t cnt_next;
  bbq_ptr_t span;
  logic     enq_fire, deq_fire, flush_ok;

  assign full      = (cnt == bbq_cnt_t'(BBQ_DEPTH));
  assign empty     = (cnt == '0);
  assign enq_ptr   = tail + 1'b1;
  assign deq_ptr   = head;
  assign in_ptr    = tail;
  assign count     = cnt;
  assign valid_vec = vld;
  assign enq_rdy   = ~full & ~flush_vld;
  assign deq_vld   = ~empty;
  assign enq_fire  = enq_vld & enq_rdy;
  assign deq_fire  = deq_vld & deq_rdy;
  assign flush_ok  = flush_vld & vld[flush_ptr];
  assign span      = flush_ptr - head;

  ptr_range_mask u_flush_mask (
    .lo_ptr (flush_ptr),
    .hi_ptr (tail),
    .mask   (range_mask)
  );

  assign flush_vec = flush_ok ? range_mask : '0;

  // Next valid vector and occupancy; enqueue never coincides with a flush since flush blocks enq_rdy.
  always_comb begin
    vld_next = vld;
    cnt_next = cnt;
    if (enq_fire) vld_next[enq_ptr] = 1'b1;
    if (deq_fire) vld_next[head]    = 1'b0;
    if (flush_ok) begin
      vld_next = vld_next & ~flush_vec;
      cnt_next = {1'b0, span} + bbq_cnt_t'(1) - bbq_cnt_t'(deq_fire);
    end else if (enq_fire && !deq_fire) begin
      cnt_next = cnt + 1'b1;
    end else if (deq_fire && !enq_fire) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Queue state registers; an invalid flush leaves state alone and raises a one-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= bbq_ptr_t'(BBQ_DEPTH - 1);
      cnt       <= '0;
      vld       <= '0;
      flush_err <= 1'b0;
    end else begin
      vld       <= vld_next;
      cnt       <= cnt_next;
      flush_err <= flush_vld & ~flush_ok;
      if (deq_fire) head <= head + 1'b1;
      if (flush_ok)
        tail <= flush_ptr;
      else if (enq_fire)
        tail <= enq_ptr;
    end
  end

endmodule

// File: tb/tb_bb_queue_ctrl.sv
module tb_bb_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_vld, deq_rdy, flush_vld;
  logic [5:0]  flush_ptr;
  logic        enq_rdy, deq_vld, flush_err, full, empty;
  logic [5:0]  enq_ptr, deq_ptr, in_ptr;
  logic [63:0] flush_vec, valid_vec;
  logic [6:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bb_queue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_vld   (enq_vld),
    .enq_rdy   (enq_rdy),
    .enq_ptr   (enq_ptr),
    .deq_vld   (deq_vld),
    .deq_rdy   (deq_rdy),
    .deq_ptr   (deq_ptr),
    .in_ptr    (in_ptr),
    .flush_vld (flush_vld),
    .flush_ptr (flush_ptr),
    .flush_vec (flush_vec),
    .flush_err (flush_err),
    .valid_vec (valid_vec),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_vld   = 1'b0;
    deq_rdy   = 1'b0;
    flush_vld = 1'b0;
    flush_ptr = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic enq_n(input int n);
    enq_vld = 1'b1;
    repeat (n) step();
    enq_vld = 1'b0;
  endtask

  task automatic deq_n(input int n);
    deq_rdy = 1'b1;
    repeat (n) step();
    deq_rdy = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #13;

    // T1 reset values
    push("t1_empty", 64'd1);          chk(64'(empty));
    push("t1_count", 64'd0);          chk(64'(count));
    push("t1_enq_ptr", 64'd0);        chk(64'(enq_ptr));
    push("t1_deq_vld", 64'd0);        chk(64'(deq_vld));
    push("t1_valid_vec", 64'd0);      chk(valid_vec);
    push("t1_flush_err", 64'd0);      chk(64'(flush_err));
    push("t1_full", 64'd0);           chk(64'(full));
    rst_n = 1'b1;
    step();

    // T2 fill to full, then a dropped 65th offer
    enq_n(64);
    push("t2_full", 64'd1);           chk(64'(full));
    push("t2_enq_rdy", 64'd0);        chk(64'(enq_rdy));
    push("t2_count", 64'd64);         chk(64'(count));
    push("t2_valid_vec", {64{1'b1}}); chk(valid_vec);
    push("t2_in_ptr", 64'd63);        chk(64'(in_ptr));
    enq_n(1);
    push("t2_drop_count", 64'd64);    chk(64'(count));
    push("t2_drop_in_ptr", 64'd63);   chk(64'(in_ptr));

    // T3 wrap of the tail past slot 63
    deq_n(10);
    push("t3_deq_ptr_mid", 64'd10);   chk(64'(deq_ptr));
    push("t3_count_mid", 64'd54);     chk(64'(count));
    enq_n(5);
    push("t3_deq_ptr", 64'd10);       chk(64'(deq_ptr));
    push("t3_in_ptr", 64'd4);         chk(64'(in_ptr));
    push("t3_count", 64'd59);         chk(64'(count));
    push("t3_valid_vec", ~64'h0000_0000_0000_03E0); chk(valid_vec);
    enq_vld = 1'b1;
    deq_rdy = 1'b1;
    step();
    idle();
    push("t3_both_count", 64'd59);    chk(64'(count));
    push("t3_both_deq_ptr", 64'd11);  chk(64'(deq_ptr));
    push("t3_both_in_ptr", 64'd5);    chk(64'(in_ptr));
    push("t3_both_valid", ~64'h0000_0000_0000_07C0); chk(valid_vec);

    // T4 non-wrapped flush, head=0 tail=20 keep 12; concurrent enq offer must drop
    do_reset();
    enq_n(21);
    push("t4_pre_in_ptr", 64'd20);    chk(64'(in_ptr));
    flush_vld = 1'b1;
    flush_ptr = 6'd12;
    enq_vld   = 1'b1;
    #1;
    push("t4_flush_vec", 64'h0000_0000_001F_E000); chk(flush_vec);
    push("t4_enq_rdy", 64'd0);        chk(64'(enq_rdy));
    step();
    idle();
    push("t4_in_ptr", 64'd12);        chk(64'(in_ptr));
    push("t4_count", 64'd13);         chk(64'(count));
    push("t4_enq_ptr", 64'd13);       chk(64'(enq_ptr));
    push("t4_valid_vec", 64'h0000_0000_0000_1FFF); chk(valid_vec);
    push("t4_flush_err", 64'd0);      chk(64'(flush_err));

    // T5 wrapped flush, head=60 tail=5 keep 62
    do_reset();
    enq_n(64);
    deq_n(60);
    enq_n(6);
    push("t5_pre_deq_ptr", 64'd60);   chk(64'(deq_ptr));
    push("t5_pre_in_ptr", 64'd5);     chk(64'(in_ptr));
    push("t5_pre_count", 64'd10);     chk(64'(count));
    flush_vld = 1'b1;
    flush_ptr = 6'd62;
    #1;
    push("t5_flush_vec", 64'h8000_0000_0000_003F); chk(flush_vec);
    step();
    idle();
    push("t5_count", 64'd3);          chk(64'(count));
    push("t5_valid_vec", 64'h7000_0000_0000_0000); chk(valid_vec);
    push("t5_in_ptr", 64'd62);        chk(64'(in_ptr));

    // T6 single entry flushed at its own slot while it retires
    do_reset();
    enq_n(8);
    deq_n(7);
    push("t6_pre_count", 64'd1);      chk(64'(count));
    push("t6_pre_deq_ptr", 64'd7);    chk(64'(deq_ptr));
    enq_vld   = 1'b1;
    deq_rdy   = 1'b1;
    flush_vld = 1'b1;
    flush_ptr = 6'd7;
    #1;
    push("t6_flush_vec", 64'd0);      chk(flush_vec);
    push("t6_enq_rdy", 64'd0);        chk(64'(enq_rdy));
    step();
    idle();
    push("t6_empty", 64'd1);          chk(64'(empty));
    push("t6_deq_ptr", 64'd8);        chk(64'(deq_ptr));
    push("t6_count", 64'd0);          chk(64'(count));
    push("t6_valid_vec", 64'd0);      chk(valid_vec);
    push("t6_flush_err_ok", 64'd0);   chk(64'(flush_err));

    // T6b flush of an unallocated slot while empty
    flush_vld = 1'b1;
    flush_ptr = 6'd30;
    #1;
    push("t6b_flush_vec", 64'd0);     chk(flush_vec);
    step();
    idle();
    push("t6b_flush_err", 64'd1);     chk(64'(flush_err));
    push("t6b_count", 64'd0);         chk(64'(count));
    push("t6b_deq_ptr", 64'd8);       chk(64'(deq_ptr));
    push("t6b_in_ptr", 64'd7);        chk(64'(in_ptr));
    push("t6b_valid_vec", 64'd0);     chk(valid_vec);
    step();
    push("t6b_flush_err_clr", 64'd0); chk(64'(flush_err));

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
